scan_sequencer: RTL
===================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DIV_W, default 16, width of prescaler divide value and counter.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  run enable; 1 = scanning, 0 = hold.
REQ-005 div  input  DIV_W  prescaler terminal count; sel advances every div+1 cycles.
REQ-006 mask  input  4  per-slot enable; bit k=1 means slot k is in the scan.
REQ-007 load  input  1  one-cycle request to force sel to load_sel.
REQ-008 load_sel  input  2  slot value applied on load.
REQ-009 sel  output  2  registered slot index; drives the 2x4 decoder input directly.
REQ-010 sel_valid  output  1  registered; 1 when in RUN and mask[sel]=1.
REQ-011 tick  output  1  registered one-cycle pulse, asserted in the cycle after sel advanced.
REQ-012 wrap  output  1  registered one-cycle pulse coincident with tick when the advance wrapped (next index <= current index).

Function
REQ-013 FSM states: IDLE, RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; each transition takes effect at the next edge.
REQ-014 Prescaler counter cnt (DIV_W bits) is cleared on every IDLE->RUN entry and held at 0 in IDLE.
REQ-015 In RUN, cnt increments by 1 per cycle; when cnt >= div, cnt returns to 0 and an advance event occurs (>= covers div lowered mid-count).
REQ-016 div=0 produces an advance event every RUN cycle.
REQ-017 Advance: sel becomes the first slot with mask=1 searching sel+1, sel+2, sel+3, sel+0 (mod 4), with wrap-around.
REQ-018 A single enabled slot equal to sel produces next=sel, tick=1, wrap=1.
REQ-019 mask=4'b0000: no advance, sel holds, tick=0, wrap=0, sel_valid=0; cnt still counts.
REQ-020 A currently masked sel is left at the next advance event per REQ-017; sel_valid=0 meanwhile.
REQ-021 load=1 (any state) sets sel=load_sel and cnt=0 at the next edge, with tick=0 and wrap=0 that cycle; load takes priority over a simultaneous advance event.
REQ-022 In IDLE, sel holds its last value; tick, wrap, sel_valid are 0.
REQ-023 mask and div changes are sampled every cycle and take effect at the next advance event; no restart occurs.
REQ-024 sel never takes an X or out-of-range value; all outputs are registered with no combinational input-to-output path.

Reset
REQ-025 rst=1 at an edge forces state=IDLE, cnt=0, sel=2'b00, sel_valid=0, tick=0, wrap=0, and overrides en and load.
REQ-026 rst asserted mid-scan aborts the count; after rst deasserts, scanning resumes per REQ-013 from sel=0 with a full div+1 period.

Structure
REQ-027 Shared package holds the FSM state typedef (IDLE, RUN) and the slot-count constant NUM_SLOTS=4.
REQ-028 The next-enabled-slot search (sel, mask -> next, wrap, any) shall be a separate combinational sub-module named slot_next.
REQ-029 The top level contains only the FSM, the prescaler, and the output registers.

Verification
REQ-030 rst then en=1, div=2, mask=4'b1111 -> sel 0,1,2,3,0 every 3 cycles; tick pulses each advance; wrap=1 only on the 3->0 advance.
REQ-031 div=0, mask=4'b1010, start sel=0 -> sel 1,3,1,3 on consecutive cycles; wrap on each 3->1 advance; sel_valid=0 before the first advance, 1 afterwards.
REQ-032 mask=4'b0100, sel=2 running -> tick=1 and wrap=1 every div+1 cycles while sel stays 2; then mask=0 -> tick=0 and sel_valid=0.
REQ-033 load=1 with load_sel=3 in the same cycle as an advance event, div=1 -> sel=3, no tick; next advance occurs 2 cycles later to sel=0 with wrap=1.
REQ-034 rst=1 mid-scan with sel=2 and cnt=5 -> next cycle all outputs 0; after release, first advance at div+1 cycles after RUN entry.
REQ-035 en dropped at sel=1 -> sel holds 1, tick stays 0; en reasserted -> first advance exactly div+1 cycles after RUN entry.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer: FSM states, slot
// count and slot/mask widths.
package scan_sequencer_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0]    slot_t;
  typedef logic [NUM_SLOTS-1:0] mask_t;

  // Slot index k steps after base, modulo NUM_SLOTS.
  function automatic slot_t slot_offset(input slot_t base, input int unsigned k);
    slot_offset = slot_t'((int'(base) + k) % NUM_SLOTS);
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle of the scan sequencer; master drives the run
// controls, slave (the sequencer) returns the registered slot outputs.
interface scan_sequencer_if
  import scan_sequencer_pkg::*;
#(
  parameter int DIV_W = 16
);

  logic             en;
  logic [DIV_W-1:0] div;
  mask_t            mask;
  logic             load;
  slot_t            load_sel;

  slot_t            sel;
  logic             sel_valid;
  logic             tick;
  logic             wrap;

  modport master (
    output en, div, mask, load, load_sel,
    input  sel, sel_valid, tick, wrap
  );

  modport slave (
    input  en, div, mask, load, load_sel,
    output sel, sel_valid, tick, wrap
  );

endinterface

// File: rtl/scan_sequencer_slot_next.sv
// Combinational next-enabled-slot search: from sel, look at sel+1, sel+2,
// sel+3, sel+0 (mod NUM_SLOTS) and return the first slot whose mask bit is set.
module slot_next
  import scan_sequencer_pkg::*;
(
  input  slot_t sel,
  input  mask_t mask,
  output slot_t next,
  output logic  wrap,
  output logic  any
);

  slot_t                cand [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit;

  // Candidate gi is the slot gi+1 steps ahead; the last candidate is sel itself.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cand
    assign cand[gi] = slot_offset(sel, gi + 1);
    assign hit[gi]  = mask[cand[gi]];
  end

  always_comb begin
    next = sel;
    // Scan from the far end so the nearest enabled candidate wins.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        next = cand[i];
      end
    end
    any  = |mask;
    wrap = any && (next <= sel);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Prescaled round-robin slot scanner: IDLE/RUN FSM, div+1 prescaler and
// registered sel/sel_valid/tick/wrap outputs; slot search lives in slot_next.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input logic             clk,
  input logic             rst,
  scan_sequencer_if.slave bus
);

  state_t           state_reg;
  logic [DIV_W-1:0] cnt_reg;
  slot_t            sel_reg;
  logic             sel_valid_reg;
  logic             tick_reg;
  logic             wrap_reg;

  slot_t            search_next;
  logic             search_wrap;
  logic             search_any;

  logic             fire;
  logic             advance;
  slot_t            sel_next;

  slot_next u_slot_next (
    .sel  (sel_reg),
    .mask (bus.mask),
    .next (search_next),
    .wrap (search_wrap),
    .any  (search_any)
  );

  // Prescaler terminal only counts while RUN is being held; dropping en
  // halts immediately so no tick can appear in an IDLE cycle.
  always_comb begin
    fire     = (state_reg == RUN) && bus.en && (cnt_reg >= bus.div);
    advance  = fire && search_any && !bus.load;
    sel_next = sel_reg;
    if (bus.load) begin
      sel_next = bus.load_sel;
    end else if (advance) begin
      sel_next = search_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sel_reg       <= '0;
      sel_valid_reg <= 1'b0;
      tick_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (bus.en) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!bus.en) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (fire || bus.load) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase

      sel_reg       <= sel_next;
      tick_reg      <= advance;
      wrap_reg      <= advance && search_wrap;
      sel_valid_reg <= bus.en && bus.mask[sel_next];
    end
  end

  assign bus.sel       = sel_reg;
  assign bus.sel_valid = sel_valid_reg;
  assign bus.tick      = tick_reg;
  assign bus.wrap      = wrap_reg;

endmodule
